// File: rtl/bit_deposit_unit_pkg.sv
`default_nettype none
// ============================================================================
// bit_deposit_unit_pkg -- shared encodings and defaults for the deposit unit
// Revision: 1.0
// ============================================================================
package bit_deposit_unit_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_IDXW  = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_deposit_unit_if.sv
`default_nettype none
// ============================================================================
// bit_deposit_unit_if -- start/busy/done coprocessor bus for the deposit unit
// Revision: 1.0
// ============================================================================
interface bit_deposit_unit_if
   import bit_deposit_unit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] mask;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, src, mask,
      input  busy, done, result
   );

   modport slave (
      input  start, src, mask,
      output busy, done, result
   );
endinterface
`default_nettype wire

// File: rtl/bit_deposit_unit.sv
`default_nettype none
// ============================================================================
// bit_deposit_unit -- multi-cycle bit scatter: src LSBs placed at mask 1-bits
// Revision: 1.0
// ============================================================================
module bit_deposit_unit
   import bit_deposit_unit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDXW  = DEFAULT_IDXW
) (
   input  wire logic            clk,
   input  wire logic            reset,
   bit_deposit_unit_if.slave    bus
);

   state_t           state;
   logic [WIDTH-1:0] src_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] acc;
   logic [IDXW-1:0]  idx;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         src_q    <= '0;
         mask_q   <= '0;
         acc      <= '0;
         idx      <= '0;
      end else begin
         case (state)
            // DONE accepts a new start exactly like IDLE, so back-to-back works
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state  <= S_RUN;
                  busy_q <= 1'b1;
                  src_q  <= bus.src;
                  mask_q <= bus.mask;
                  acc    <= '0;
                  idx    <= '0;
               end else begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            end

            S_RUN: begin
               if (mask_q == '0) begin
                  state    <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= acc;
               end else begin
                  // acc starts cleared and each idx is visited once, so OR acts as a bit write
                  if (mask_q[0]) begin
                     acc   <= acc | (WIDTH'(src_q[0]) << idx);
                     src_q <= src_q >> 1;
                  end
                  mask_q <= mask_q >> 1;
                  idx    <= idx + IDXW'(1);
               end
            end

            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bit_deposit_unit.sv
`default_nettype none
// ============================================================================
// tb_bit_deposit_unit -- directed stimulus with a queued scoreboard monitor
// Revision: 1.0
// ============================================================================
module tb_bit_deposit_unit;

   logic clk;
   logic reset;
   int   cyc;
   int   passes;
   int   checks;

   typedef struct {
      logic [31:0] res;
      int          done_cyc;
      int          run_len;
   } exp_t;

   exp_t q[$];

   bit_deposit_unit_if #(.WIDTH(32)) bus ();

   bit_deposit_unit #(.WIDTH(32), .IDXW(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic logic [31:0] compress(input logic [31:0] v, input logic [31:0] m);
      logic [31:0] r;
      int          k;
      r = '0;
      k = 0;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) begin
            r[k] = v[i];
            k++;
         end
      end
      return r;
   endfunction

   // Scoreboard monitor: pops one expectation per done pulse
   initial begin
      int   run;
      logic prev_done;
      exp_t e;
      run       = 0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.busy) begin
            run++;
         end else if (bus.done) begin
            if (prev_done) check("done_single_pulse", 32'd1, 32'd0);
            if (q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("result", bus.result, e.res);
               check("done_cycle", 32'(cyc), 32'(e.done_cyc));
               check("busy_run_len", 32'(run), 32'(e.run_len));
            end
            run = 0;
         end else begin
            run = 0;
         end
         prev_done = bus.done;
      end
   end

   // Called at a negedge; start is sampled at the next posedge
   task automatic issue(input logic [31:0] s, input logic [31:0] m, input logic [31:0] r,
                        input int h, input bit expect_done);
      bus.start = 1'b1;
      bus.src   = s;
      bus.mask  = m;
      if (expect_done) q.push_back('{r, cyc + 2 + h, h + 1});
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.src   = $urandom;
      bus.mask  = $urandom;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] m;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.src   = '0;
      bus.mask  = '0;
      passes    = 0;
      checks    = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_result", bus.result, 32'h0);

      issue(32'h000000FF, 32'h0F0F0F0F, 32'h00000F0F, 28, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'hFFFFFFFF, 32'h00000000, 32'h00000000, 0, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'h00000001, 32'h80000000, 32'h80000000, 32, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32, 1'b1);
      wait_done();
      @(negedge clk);

      // start pulsed mid-run must be ignored
      issue(32'h000000A5, 32'h000000FF, 32'h000000A5, 8, 1'b1);
      @(negedge clk);
      bus.start = 1'b1;
      bus.src   = 32'hFFFFFFFF;
      bus.mask  = 32'hFFFFFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      // back-to-back: start asserted in the DONE cycle
      issue(32'h00000003, 32'h00000E0F, 32'h00000003, 12, 1'b1);
      wait_done();
      @(negedge clk);

      m = {16'h0000, 16'h0E0F};
      issue(compress(32'h0FFFFFFF, m), m, 32'h0FFFFFFF & m, 12, 1'b1);
      wait_done();
      @(negedge clk);
      m = {16'h0000, 16'h000F};
      issue(compress(32'h0FFFFFFF, m), m, 32'h0FFFFFFF & m, 4, 1'b1);
      wait_done();
      repeat (5) @(negedge clk);
      check("result_hold_idle", bus.result, 32'h0000000F);

      issue(32'h000000FF, 32'h0F0F0F0F, 32'h00000F0F, 28, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32, 1'b0);
      repeat (5) @(negedge clk);
      check("result_stable_run", bus.result, 32'h00000F0F);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("midrun_reset_busy", 32'(bus.busy), 32'd0);
      check("midrun_reset_done", 32'(bus.done), 32'd0);
      check("midrun_reset_result", bus.result, 32'h0);
      repeat (45) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
      $fatal(1);
   end

endmodule
`default_nettype wire
